// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared defaults, status bit positions and event type for the IO device hub.
package io_hub_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF = 8;
  localparam int STATUS_ID_DEF = 15;
  localparam int OVERFLOW_BIT = DATA_W_DEF - 1;
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [DATA_W_DEF-1:0] data;
  } io_event_t;
endpackage

// File: rtl/io_device_hub_if.sv
// io_device_hub_if: CPU read/write, IPC input and IPC output-event signals of the IO device hub.
interface io_device_hub_if
  import io_hub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF
);
  logic [ID_W-1:0] dev_id;
  logic wr_en;
  logic [DATA_W-1:0] wr_data;
  logic rd_en;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic out_valid;
  logic out_ready;
  logic [ID_W-1:0] out_id;
  logic [DATA_W-1:0] out_data;
  logic out_full;
  logic in_valid;
  logic [ID_W-1:0] in_id;
  logic [DATA_W-1:0] in_data;
  modport master (
    output dev_id, wr_en, wr_data, rd_en, out_ready, in_valid, in_id, in_data,
    input rd_data, rd_valid, out_valid, out_id, out_data, out_full
  );
  modport slave (
    input dev_id, wr_en, wr_data, rd_en, out_ready, in_valid, in_id, in_data,
    output rd_data, rd_valid, out_valid, out_id, out_data, out_full
  );
endinterface

// File: rtl/io_out_fifo.sv
// io_out_fifo: show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module io_out_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/io_device_hub.sv
// io_device_hub: N_DEVICES IO channels with fresh-flagged input latches and a buffered output event FIFO.
// IO_STATUS_EN maps STATUS_ID to a status register {overflow, fresh bitmap}; otherwise it is an ordinary device.
module io_device_hub
  import io_hub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int N_DEVICES = 16,
  parameter int OUT_DEPTH = 8,
  parameter int STATUS_ID = STATUS_ID_DEF
) (
  input logic clk,
  input logic reset,
  io_device_hub_if.slave bus
);
  localparam int IW = N_DEVICES > 1 ? $clog2(N_DEVICES) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [ID_W:0] N_DEV = (ID_W+1)'(N_DEVICES);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
  } ev_t;
  if (N_DEVICES > DATA_W - 1 || N_DEVICES > 2**ID_W || STATUS_ID >= 2**ID_W || OUT_DEPTH < 2)
    $error("io_device_hub: illegal parameter combination");
  logic [DATA_W-1:0] latch [N_DEVICES];
  logic [N_DEVICES-1:0] fresh, fresh_nxt;
  logic overflow, in_hit, dev_ok, is_stat, push, pop, ovf_evt, stat_clr, fifo_empty, fifo_full;
  logic [DATA_W-1:0] dev_val, rd_val;
  logic [CW-1:0] count;
  ev_t head;
`ifdef IO_STATUS_EN
  logic [DATA_W-1:0] stat_val;
  assign is_stat = bus.dev_id == ID_W'(STATUS_ID);
  always_comb begin
    stat_val = '0;
    stat_val[DATA_W-1] = overflow;
    stat_val[N_DEVICES-1:0] = fresh;
  end
  assign rd_val = is_stat ? stat_val : dev_val;
`else
  assign is_stat = 1'b0;
  assign rd_val = dev_val;
`endif
  assign in_hit = bus.in_valid & ({1'b0, bus.in_id} < N_DEV);
  assign dev_ok = ({1'b0, bus.dev_id} < N_DEV) & ~is_stat;
  assign dev_val = dev_ok ? latch[bus.dev_id[IW-1:0]] : '0;
  assign push = bus.wr_en & dev_ok;
  assign pop = bus.out_ready & ~fifo_empty;
  assign ovf_evt = push & (count == CW'(OUT_DEPTH)) & ~pop;
  assign stat_clr = bus.wr_en & is_stat;
  // an arrival in the same cycle as a read of that device leaves it fresh
  always_comb begin
    fresh_nxt = fresh;
    if (bus.rd_en && dev_ok) fresh_nxt[bus.dev_id[IW-1:0]] = 1'b0;
    if (in_hit) fresh_nxt[bus.in_id[IW-1:0]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
      fresh <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_DEVICES; i++) latch[i] <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_val;
      fresh <= fresh_nxt;
      overflow <= (overflow | ovf_evt) & ~stat_clr;
      if (in_hit) latch[bus.in_id[IW-1:0]] <= bus.in_data;
    end
  end
  io_out_fifo #(.W(ID_W + DATA_W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.out_ready),
    .din   ({bus.dev_id, bus.wr_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_full = fifo_full;
  assign bus.out_id = head.id;
  assign bus.out_data = head.data;
endmodule

// File: tb/tb_io_device_hub.sv
// tb_io_device_hub: scoreboard bench for io_device_hub; status checks are active when IO_STATUS_EN is defined.
module tb_io_device_hub;
  import io_hub_pkg::*;
  localparam int N = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  io_device_hub_if #(.DATA_W(32), .ID_W(8)) bus ();
  io_device_hub #(
    .DATA_W(32), .ID_W(8), .N_DEVICES(N), .OUT_DEPTH(DEPTH), .STATUS_ID(STATUS_ID_DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  int errors = 0;
  int checks = 0;
  io_event_t ev_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mlat [N];
  logic [N-1:0] mfresh;
  logic movf;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic is_stat(input logic [7:0] d);
`ifdef IO_STATUS_EN
    return d == 8'(STATUS_ID_DEF);
`else
    return 1'b0;
`endif
  endfunction

  // model is updated from the inputs present before the edge, then the edge's results are checked
  task automatic tick();
    io_event_t e;
    logic [31:0] v;
    if (reset) begin
      ev_q.delete();
      rd_q.delete();
      for (int i = 0; i < N; i++) mlat[i] = '0;
      mfresh = '0;
      movf = 1'b0;
    end else begin
      check("out_valid", bus.out_valid, ev_q.size() != 0);
      check("out_full", bus.out_full, ev_q.size() == DEPTH);
      if (bus.out_ready && ev_q.size() != 0) begin
        e = ev_q.pop_front();
        check("out_id", bus.out_id, e.id);
        check("out_data", bus.out_data, e.data);
      end
      if (bus.rd_en) begin
        v = '0;
        if (is_stat(bus.dev_id)) begin
          v[OVERFLOW_BIT] = movf;
          v[N-1:0] = mfresh;
        end else if (bus.dev_id < N) begin
          v = mlat[bus.dev_id];
          mfresh[bus.dev_id] = 1'b0;
        end
        rd_q.push_back(v);
      end
      if (bus.wr_en) begin
        if (is_stat(bus.dev_id)) movf = 1'b0;
        else if (bus.dev_id < N) begin
          if (ev_q.size() < DEPTH) ev_q.push_back('{id: bus.dev_id, data: bus.wr_data});
          else movf = 1'b1;
        end
      end
      if (bus.in_valid && bus.in_id < N) begin
        mlat[bus.in_id] = bus.in_data;
        mfresh[bus.in_id] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("rd_valid", bus.rd_valid, rd_q.size() != 0);
    if (rd_q.size() != 0) begin
      v = rd_q.pop_front();
      if (bus.rd_valid) check("rd_data", bus.rd_data, v);
    end
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [7:0] dev, input logic [31:0] wd,
                     input logic iv, input logic [7:0] iid, input logic [31:0] idat, input logic rdy);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.dev_id = dev;
    bus.wr_data = wd;
    bus.in_valid = iv;
    bus.in_id = iid;
    bus.in_data = idat;
    bus.out_ready = rdy;
    tick();
  endtask

  task automatic rd(input logic [7:0] dev);
    cyc(0, 1, dev, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] dev, input logic [31:0] wd, input logic rdy);
    cyc(1, 0, dev, wd, 0, 0, 0, rdy);
  endtask

  task automatic inp(input logic [7:0] iid, input logic [31:0] idat);
    cyc(0, 0, 0, 0, 1, iid, idat, 0);
  endtask

  initial begin
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    rd(3);
    inp(5, 32'hDEADBEEF);
`ifdef IO_STATUS_EN
    rd(8'(STATUS_ID_DEF));
`endif
    rd(5);
`ifdef IO_STATUS_EN
    rd(8'(STATUS_ID_DEF));
`endif
    inp(2, 32'h7);
    cyc(0, 1, 2, 0, 1, 2, 32'h11, 0);
`ifdef IO_STATUS_EN
    rd(8'(STATUS_ID_DEF));
`endif
    rd(2);
    cyc(0, 1, 20, 0, 1, 20, 32'h55, 0);
    wr(1, 32'hA, 0);
    wr(2, 32'hB, 0);
    wr(3, 32'hC, 0);
    wr(17, 32'hD, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 32'h100 + i, 0);
    wr(9, 32'h1FF, 0);
`ifdef IO_STATUS_EN
    rd(8'(STATUS_ID_DEF));
`endif
    wr(10, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IO_STATUS_EN
    wr(8'(STATUS_ID_DEF), 0, 0);
    rd(8'(STATUS_ID_DEF));
`endif
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(i + 4), 32'h300 + i, 1, 8'(i), 32'h400 + i, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    rd(0);
    rd(5);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 17)),
          $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 17)), $urandom,
          1'($urandom_range(0, 3) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_device_hub.md
Name: io_device_hub

Overview:
- Parametrised successor to the single-bank IO device block: N_DEVICES addressable IO channels behind one CPU-side port.
- Per-device input latches with sticky "fresh" flags, and a registered read path.
- Buffered output path: each CPU write becomes a {device_id, value} event in a FIFO, drained to the IPC side by valid/ready handshake.
- Sits between the CPU's IO instruction unit and the IPC bridge.

Parameters:
- DATA_W, 32, width of device values
- ID_W, 8, width of device id
- N_DEVICES, 16, number of implemented devices (ids 0..N_DEVICES-1); must be <= DATA_W-1 and <= 2**ID_W
- OUT_DEPTH, 8, output event FIFO depth; power of two, >= 2
- STATUS_ID, 15, device id of the status register (used only with IO_STATUS_EN)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- dev_id  in  ID_W  device addressed by rd_en/wr_en
- wr_en  in  1  CPU write strobe
- wr_data  in  DATA_W  CPU write value
- rd_en  in  1  CPU read strobe
- rd_data  out  DATA_W  read result, registered
- rd_valid  out  1  one-cycle pulse qualifying rd_data
- out_valid  out  1  FIFO head valid toward IPC
- out_ready  in  1  IPC accepts head
- out_id  out  ID_W  head device id
- out_data  out  DATA_W  head value
- out_full  out  1  FIFO full (CPU should not write)
- in_valid  in  1  IPC input update; always accepted
- in_id  in  ID_W  device being updated
- in_data  in  DATA_W  new input value

Behaviour:
- Reset (sync, active-high; dominates all other inputs that cycle):
  - rd_data=0, rd_valid=0, out_valid=0, out_full=0
  - FIFO emptied; all input latches=0; all fresh flags=0; overflow flag=0
  - out_id/out_data are don't-care while out_valid=0
  - Reset mid-handshake discards queued events.
- Input path:
  - in_valid with in_id < N_DEVICES: latch[in_id] <= in_data, fresh[in_id] <= 1 at the next edge.
  - in_id >= N_DEVICES: ignored.
- Read path:
  - rd_en in cycle N: rd_data = latch[dev_id] and rd_valid=1 in cycle N+1; fresh[dev_id] cleared.
  - dev_id >= N_DEVICES: returns 0, rd_valid still pulses.
  - rd_valid is 0 in any cycle not following rd_en.
  - Same-cycle rd_en and in_valid on the same id: read returns the OLD value; fresh ends 1 (the arrival wins).
- Write path:
  - wr_en with dev_id < N_DEVICES pushes {dev_id, wr_data}; dev_id >= N_DEVICES is dropped silently.
  - wr_en and rd_en in the same cycle are both honoured.
- FIFO:
  - Show-ahead: out_valid = (count != 0), with head on out_id/out_data.
  - Pop on out_valid & out_ready.
  - Push→out_valid latency is 1 cycle.
  - count width clog2(OUT_DEPTH)+1; read/write pointers wrap modulo OUT_DEPTH.
  - out_full = (count == OUT_DEPTH).
  - Push while full with a pop in the same cycle: accepted, count unchanged.
  - Push while full with no pop: event dropped and overflow sticky flag set.
  - Push and pop while empty: not a bypass; the pop is impossible because out_valid=0.
  - Events drain in write order.
- No FSM beyond the FIFO pointers; all outputs derive from registers.

Optional Feature:
- Macro IO_STATUS_EN.
- Defined:
  - dev_id == STATUS_ID is the status register, not a device.
  - Read returns bit[DATA_W-1]=overflow, bits[N_DEVICES-1:0]=fresh bitmap snapshot, all other bits 0; fresh flags are not cleared by a status read.
  - Write to STATUS_ID clears overflow and is not enqueued.
  - N_DEVICES must be <= STATUS_ID or STATUS_ID >= N_DEVICES is treated as reserved; STATUS_ID wins when they overlap.
- Undefined:
  - STATUS_ID is an ordinary device.
  - overflow is kept internally but is not observable.

Decomposition:
- Package io_hub_pkg:
  - Default ID_W/DATA_W.
  - STATUS_ID default.
  - Status bit positions (OVERFLOW_BIT).
  - Packed event typedef {id, data}.
- Sub-module io_out_fifo: parametrised synchronous FIFO (width ID_W+DATA_W, depth OUT_DEPTH) with push/pop/full/empty/count. Reusable elsewhere in the design.

Test Plan:
- Reset then rd_en dev 3 → next cycle rd_valid=1, rd_data=0; out_valid=0, out_full=0.
- in_valid id 5 data 0xDEADBEEF, then rd_en dev 5 → rd_data=0xDEADBEEF. With IO_STATUS_EN, a status read before the dev-5 read has bit5=1 and after it bit5=0.
- Same cycle in_valid id 2 data 0x11 and rd_en dev 2 (latch was 0x7) → rd_data=0x7; a following status read shows fresh[2]=1.
- Writes to devs 1,2,3 (values 0xA,0xB,0xC) with out_ready=0, then out_ready=1 → events drain in order (1,0xA),(2,0xB),(3,0xC); out_valid drops after the third pop.
- 8 writes with out_ready=0 → out_full=1. A 9th write is dropped and overflow=1 (status bit31). A 9th write with out_ready=1 in the same cycle is accepted, count stays 8. Status write clears overflow.
- Reset asserted while the FIFO holds 4 events with out_ready=1 → next cycle out_valid=0, count=0; fresh flags and latches cleared.
